// File: rtl/tpu_instr_sequencer.sv
// tpu_instr_sequencer
//   Host-side instruction issuer for the TPU. It keeps a program memory of
//   80-bit instructions and streams a window of it (base_addr,
//   instr_count) into the TPU instruction FIFO. The FIFO back-pressure
//   (instr_fifo_full) is honoured. After a synchronize opcode (8'hFF) the
//   sequencer can stall until the TPU pulses synchronize. A cycle bound
//   limits that stall.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   prog_wr_en/addr/data program memory write port (dropped while busy)
//   start               single-cycle run request (ignored while busy)
//   base_addr           first entry of the run
//   instr_count         number of entries to issue (0 = empty run)
//   abort               abandon the current run, no done pulse
//   instr_fifo_full     TPU FIFO back-pressure
//   synchronize         TPU synchronize pulse
//   lower/middle/upper_instr_word  instr[31:0] / [63:32] / [79:64]
//   instr_write_enable  per-word write strobe, 3'b111 for one cycle per issue
//   busy                run in progress
//   done                single-cycle end-of-run pulse
//   timeout_err         sticky sync-timeout flag, cleared by the next accepted start
//   issued_count        instructions issued since reset (wraps)
module tpu_instr_sequencer #(
  parameter int PROG_DEPTH   = 64,
  parameter int SYNC_TIMEOUT = 65536,
  parameter bit WAIT_ON_SYNC = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          prog_wr_en,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_wr_addr,
  input  logic [79:0]                   prog_wr_data,
  input  logic                          start,
  input  logic [$clog2(PROG_DEPTH)-1:0] base_addr,
  input  logic [$clog2(PROG_DEPTH):0]   instr_count,
  input  logic                          abort,
  input  logic                          instr_fifo_full,
  input  logic                          synchronize,
  output logic [31:0]                   lower_instr_word,
  output logic [31:0]                   middle_instr_word,
  output logic [15:0]                   upper_instr_word,
  output logic [2:0]                    instr_write_enable,
  output logic                          busy,
  output logic                          done,
  output logic                          timeout_err,
  output logic [31:0]                   issued_count
);

  localparam int          AW        = $clog2(PROG_DEPTH);
  localparam int          CW        = AW + 1;
  localparam logic [7:0]  OP_SYNC   = 8'hFF;
  localparam logic [31:0] SYNC_LAST = 32'(SYNC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_SYNC,
    S_DONE
  } state_t;

  logic [79:0]   prog_mem [PROG_DEPTH];
  logic [79:0]   rd_data_p1;
  state_t        state;
  logic [AW-1:0] ptr;
  logic [CW-1:0] remaining;
  logic [31:0]   sync_cnt;

  // Program memory write port; the program is frozen while a run is active.
  always_ff @(posedge clk) begin
    if (prog_wr_en && !busy) begin
      prog_mem[prog_wr_addr] <= prog_wr_data;
    end
  end

  // Stage p0 -> p1: registered read of the entry presented in FETCH.
  // The read data stays valid through any ISSUE stall because no new FETCH
  // happens until the instruction has been accepted.
  always_ff @(posedge clk) begin
    if (state == S_FETCH) begin
      rd_data_p1 <= prog_mem[ptr];
    end
  end

  // Stage p1 -> outputs: sequencing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      ptr                <= '0;
      remaining          <= '0;
      sync_cnt           <= '0;
      lower_instr_word   <= '0;
      middle_instr_word  <= '0;
      upper_instr_word   <= '0;
      instr_write_enable <= 3'b000;
      busy               <= 1'b0;
      done               <= 1'b0;
      timeout_err        <= 1'b0;
      issued_count       <= '0;
    end else begin
      instr_write_enable <= 3'b000;
      done               <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            // busy stays high for one cycle after DONE, which also blocks
            // a start arriving in that cycle.
            if (start && !busy) begin
              ptr         <= base_addr;
              remaining   <= instr_count;
              timeout_err <= 1'b0;
              busy        <= 1'b1;
              state       <= (instr_count == '0) ? S_DONE : S_FETCH;
            end else begin
              busy <= 1'b0;
            end
          end
          S_FETCH: begin
            state <= S_ISSUE;
          end
          S_ISSUE: begin
            if (!instr_fifo_full) begin
              lower_instr_word   <= rd_data_p1[31:0];
              middle_instr_word  <= rd_data_p1[63:32];
              upper_instr_word   <= rd_data_p1[79:64];
              instr_write_enable <= 3'b111;
              issued_count       <= issued_count + 32'd1;
              remaining          <= remaining - CW'(1);
              ptr                <= ptr + AW'(1);
              if (WAIT_ON_SYNC && (rd_data_p1[79:72] == OP_SYNC)) begin
                sync_cnt <= '0;
                state    <= S_WAIT_SYNC;
              end else if (remaining == CW'(1)) begin
                state <= S_DONE;
              end else begin
                state <= S_FETCH;
              end
            end
          end
          S_WAIT_SYNC: begin
            if (synchronize) begin
              state <= (remaining == '0) ? S_DONE : S_FETCH;
            end else if ((sync_cnt + 32'd1) >= SYNC_LAST) begin
              // Counter reaches SYNC_TIMEOUT-1: abandon the rest of the run.
              timeout_err <= 1'b1;
              state       <= S_DONE;
            end else begin
              sync_cnt <= sync_cnt + 32'd1;
            end
          end
          S_DONE: begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tpu_instr_sequencer.sv
// Self-checking bench for tpu_instr_sequencer. Two instances: dut_a with
// default parameters and dut_t with SYNC_TIMEOUT=16. They share every input
// except start. Issued writes are captured per instance and compared in
// order against an expectation queue filled when each run is launched.
module tb_tpu_instr_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst             = 1'b1;
  logic        prog_wr_en      = 1'b0;
  logic [5:0]  prog_wr_addr    = '0;
  logic [79:0] prog_wr_data    = '0;
  logic        start_a         = 1'b0;
  logic        start_t         = 1'b0;
  logic [5:0]  base_addr       = '0;
  logic [6:0]  instr_count     = '0;
  logic        abort           = 1'b0;
  logic        instr_fifo_full = 1'b0;
  logic        synchronize     = 1'b0;

  logic [31:0] lower_a, middle_a, lower_t, middle_t;
  logic [15:0] upper_a, upper_t;
  logic [2:0]  we_a, we_t;
  logic        busy_a, busy_t, done_a, done_t, terr_a, terr_t;
  logic [31:0] icnt_a, icnt_t;

  tpu_instr_sequencer #(.PROG_DEPTH(64), .SYNC_TIMEOUT(65536), .WAIT_ON_SYNC(1'b1)) dut_a (
    .clk(clk), .rst(rst), .prog_wr_en(prog_wr_en), .prog_wr_addr(prog_wr_addr),
    .prog_wr_data(prog_wr_data), .start(start_a), .base_addr(base_addr),
    .instr_count(instr_count), .abort(abort), .instr_fifo_full(instr_fifo_full),
    .synchronize(synchronize), .lower_instr_word(lower_a), .middle_instr_word(middle_a),
    .upper_instr_word(upper_a), .instr_write_enable(we_a), .busy(busy_a), .done(done_a),
    .timeout_err(terr_a), .issued_count(icnt_a)
  );

  tpu_instr_sequencer #(.PROG_DEPTH(64), .SYNC_TIMEOUT(16), .WAIT_ON_SYNC(1'b1)) dut_t (
    .clk(clk), .rst(rst), .prog_wr_en(prog_wr_en), .prog_wr_addr(prog_wr_addr),
    .prog_wr_data(prog_wr_data), .start(start_t), .base_addr(base_addr),
    .instr_count(instr_count), .abort(abort), .instr_fifo_full(instr_fifo_full),
    .synchronize(synchronize), .lower_instr_word(lower_t), .middle_instr_word(middle_t),
    .upper_instr_word(upper_t), .instr_write_enable(we_t), .busy(busy_t), .done(done_t),
    .timeout_err(terr_t), .issued_count(icnt_t)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [79:0] model_mem [64];
  logic [79:0] exp_q_a [$];
  logic [79:0] exp_q_t [$];

  logic [79:0] obs_word_a [64];
  logic [2:0]  obs_we_a   [64];
  logic [79:0] obs_word_t [64];
  logic [2:0]  obs_we_t   [64];
  int writes_a = 0, writes_t = 0, dones_a = 0, dones_t = 0, last_done_a = 0;
  int rd_a = 0, rd_t = 0;
  int exp_issued_a = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we_a !== 3'b000) begin
      if (writes_a < 64) begin
        obs_we_a[writes_a]   <= we_a;
        obs_word_a[writes_a] <= {upper_a, middle_a, lower_a};
      end
      writes_a <= writes_a + 1;
    end
    if (done_a === 1'b1) begin
      dones_a     <= dones_a + 1;
      last_done_a <= cyc;
    end
  end

  always @(negedge clk) begin
    if (we_t !== 3'b000) begin
      if (writes_t < 64) begin
        obs_we_t[writes_t]   <= we_t;
        obs_word_t[writes_t] <= {upper_t, middle_t, lower_t};
      end
      writes_t <= writes_t + 1;
    end
    if (done_t === 1'b1) dones_t <= dones_t + 1;
  end

  function automatic logic [79:0] mk(input logic [7:0] op, input logic [15:0] len,
                                     input logic [23:0] bufa, input logic [23:0] acc);
    return {op, 8'h00, len, bufa, acc};
  endfunction

  task automatic prog_write(input int addr, input logic [79:0] data);
    prog_wr_addr = 6'(addr);
    prog_wr_data = data;
    prog_wr_en   = 1'b1;
    @(posedge clk); #1;
    prog_wr_en   = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic start_run_a(input int base, input int count);
    base_addr   = 6'(base);
    instr_count = 7'(count);
    start_a     = 1'b1;
    @(posedge clk); #1;
    start_a     = 1'b0;
  endtask

  task automatic start_run_t(input int base, input int count);
    base_addr   = 6'(base);
    instr_count = 7'(count);
    start_t     = 1'b1;
    @(posedge clk); #1;
    start_t     = 1'b0;
  endtask

  task automatic wait_writes_a(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (writes_a >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_writes_t(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (writes_t >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done_a(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (dones_a >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_sync();
    synchronize = 1'b1;
    @(posedge clk); #1;
    synchronize = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk); #1;
    checks++;
    if ({lower_a, middle_a, upper_a, we_a, busy_a, done_a, terr_a, icnt_a} !== '0)
      begin errors++; $display("FAIL reset_a: got we=%b busy=%b done=%b terr=%b icnt=%0d words=%h expected all zero",
        we_a, busy_a, done_a, terr_a, icnt_a, {upper_a, middle_a, lower_a}); end
    checks++;
    if ({lower_t, middle_t, upper_t, we_t, busy_t, done_t, terr_t, icnt_t} !== '0)
      begin errors++; $display("FAIL reset_t: got we=%b busy=%b icnt=%0d expected all zero", we_t, busy_t, icnt_t); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit ok; int w0, d0, s;
    logic [79:0] e;
    prog_write(0, mk(8'h08, 16'd14, 24'h0, 24'h0));
    prog_write(1, mk(8'h20, 16'd14, 24'h0, 24'h0));
    prog_write(2, mk(8'h89, 16'd14, 24'h0E, 24'h0));
    prog_write(3, mk(8'hFF, 16'd0, 24'h0, 24'h0));
    for (int i = 0; i < 4; i++) exp_q_a.push_back(model_mem[i]);
    w0 = writes_a; d0 = dones_a;
    start_run_a(0, 4); s = cyc;
    wait_writes_a(w0 + 4, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_writes: got %0d writes expected 4", writes_a - w0); end
    checks++;
    if (busy_a !== 1'b1 || dones_a != d0)
      begin errors++; $display("FAIL basic_wait_sync: got busy=%b dones=%0d expected busy=1 dones=%0d", busy_a, dones_a, d0); end
    repeat (20) @(posedge clk);
    #1;
    pulse_sync();
    wait_done_a(d0 + 1, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done: got no done expected one done pulse"); end
    checks++;
    if (last_done_a - s != 30) begin errors++; $display("FAIL basic_run_len: got %0d expected 30", last_done_a - s); end
    repeat (5) @(posedge clk);
    #1;
    for (int i = rd_a; i < writes_a && i < 64; i++) begin
      checks++;
      if (exp_q_a.size() == 0) begin errors++; $display("FAIL basic_order: got unexpected write %h expected none", obs_word_a[i]); end
      else begin
        e = exp_q_a.pop_front();
        if ({obs_we_a[i], obs_word_a[i]} !== {3'b111, e})
          begin errors++; $display("FAIL basic_order: got we=%b %h expected we=111 %h", obs_we_a[i], obs_word_a[i], e); end
      end
    end
    rd_a = writes_a;
    exp_issued_a += 4;
    checks++;
    if (obs_word_a[w0 + 2][79:64] !== 16'h8900)
      begin errors++; $display("FAIL basic_upper3: got %h expected 8900", obs_word_a[w0 + 2][79:64]); end
    checks++;
    if (dones_a != d0 + 1 || icnt_a !== 32'(exp_issued_a) || terr_a !== 1'b0 || busy_a !== 1'b0)
      begin errors++; $display("FAIL basic_status: got dones=%0d icnt=%0d terr=%b busy=%b expected dones=%0d icnt=%0d terr=0 busy=0",
        dones_a - d0, icnt_a, terr_a, busy_a, 1, exp_issued_a); end
  endtask

  task automatic test_fifo_stall();
    bit ok; int w0, d0, s;
    logic [79:0] e;
    for (int i = 0; i < 4; i++) exp_q_a.push_back(model_mem[i]);
    w0 = writes_a; d0 = dones_a;
    start_run_a(0, 4); s = cyc;
    wait_writes_a(w0 + 1, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_first_write: got none expected one write"); end
    @(posedge clk); #1;
    instr_fifo_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checks++;
      if (we_a !== 3'b000 || {upper_a, middle_a, lower_a} !== model_mem[0])
        begin errors++; $display("FAIL stall_hold: got we=%b words=%h expected we=000 words=%h",
          we_a, {upper_a, middle_a, lower_a}, model_mem[0]); end
    end
    @(posedge clk); #1;
    instr_fifo_full = 1'b0;
    wait_writes_a(w0 + 4, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_writes: got %0d expected 4", writes_a - w0); end
    repeat (20) @(posedge clk);
    #1;
    pulse_sync();
    wait_done_a(d0 + 1, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_done: got no done expected done"); end
    checks++;
    if (last_done_a - s != 40) begin errors++; $display("FAIL stall_run_len: got %0d expected 40", last_done_a - s); end
    repeat (5) @(posedge clk);
    #1;
    for (int i = rd_a; i < writes_a && i < 64; i++) begin
      checks++;
      if (exp_q_a.size() == 0) begin errors++; $display("FAIL stall_order: got unexpected write %h expected none", obs_word_a[i]); end
      else begin
        e = exp_q_a.pop_front();
        if ({obs_we_a[i], obs_word_a[i]} !== {3'b111, e})
          begin errors++; $display("FAIL stall_order: got we=%b %h expected we=111 %h", obs_we_a[i], obs_word_a[i], e); end
      end
    end
    rd_a = writes_a;
    exp_issued_a += 4;
    checks++;
    if (icnt_a !== 32'(exp_issued_a)) begin errors++; $display("FAIL stall_icnt: got %0d expected %0d", icnt_a, exp_issued_a); end
  endtask

  task automatic test_zero_count();
    int w0, d0, s;
    w0 = writes_a; d0 = dones_a;
    start_run_a(5, 0); s = cyc;
    @(negedge clk); #1;
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b1)
      begin errors++; $display("FAIL zero_cycle1: got done=%b busy=%b expected done=0 busy=1", done_a, busy_a); end
    @(negedge clk); #1;
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b1)
      begin errors++; $display("FAIL zero_done: got done=%b busy=%b expected done=1 busy=1", done_a, busy_a); end
    @(negedge clk); #1;
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0)
      begin errors++; $display("FAIL zero_after: got done=%b busy=%b expected done=0 busy=0", done_a, busy_a); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (writes_a != w0 || dones_a != d0 + 1 || icnt_a !== 32'(exp_issued_a))
      begin errors++; $display("FAIL zero_status: got writes=%0d dones=%0d icnt=%0d expected writes=0 dones=1 icnt=%0d",
        writes_a - w0, dones_a - d0, icnt_a, exp_issued_a); end
  endtask

  task automatic test_sync_timeout();
    bit ok; int wt0, k;
    logic [79:0] e;
    prog_write(4, mk(8'h30, 16'd7, 24'h11, 24'h22));
    exp_q_t.push_back(model_mem[2]);
    exp_q_t.push_back(model_mem[3]);
    wt0 = writes_t;
    start_run_t(2, 3);
    wait_writes_t(wt0 + 2, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL tmo_writes: got %0d expected 2", writes_t - wt0); end
    k = 0;
    while (k < 40) begin
      @(negedge clk); #1;
      k++;
      if (done_t === 1'b1) break;
    end
    checks++;
    if (k != 16) begin errors++; $display("FAIL tmo_done_delay: got %0d expected 16", k); end
    checks++;
    if (terr_t !== 1'b1) begin errors++; $display("FAIL tmo_err_set: got %b expected 1", terr_t); end
    repeat (10) @(posedge clk);
    #1;
    for (int i = rd_t; i < writes_t && i < 64; i++) begin
      checks++;
      if (exp_q_t.size() == 0) begin errors++; $display("FAIL tmo_order: got unexpected write %h expected none", obs_word_t[i]); end
      else begin
        e = exp_q_t.pop_front();
        if ({obs_we_t[i], obs_word_t[i]} !== {3'b111, e})
          begin errors++; $display("FAIL tmo_order: got we=%b %h expected we=111 %h", obs_we_t[i], obs_word_t[i], e); end
      end
    end
    rd_t = writes_t;
    checks++;
    if (writes_t != wt0 + 2 || icnt_t !== 32'd2 || terr_t !== 1'b1 || busy_t !== 1'b0)
      begin errors++; $display("FAIL tmo_status: got writes=%0d icnt=%0d terr=%b busy=%b expected 2 2 1 0",
        writes_t - wt0, icnt_t, terr_t, busy_t); end
    start_run_t(0, 0);
    @(negedge clk); #1;
    checks++;
    if (terr_t !== 1'b0) begin errors++; $display("FAIL tmo_err_clear: got %b expected 0", terr_t); end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_wrap_and_busy();
    bit ok; int w0, d0;
    logic [79:0] e;
    prog_write(62, mk(8'h41, 16'd62, 24'hABCDEF, 24'h000062));
    prog_write(63, mk(8'h42, 16'd63, 24'h123456, 24'h000063));
    exp_q_a.push_back(model_mem[62]);
    exp_q_a.push_back(model_mem[63]);
    exp_q_a.push_back(model_mem[0]);
    exp_q_a.push_back(model_mem[1]);
    w0 = writes_a; d0 = dones_a;
    start_run_a(62, 4);
    prog_wr_addr = 6'd0;
    prog_wr_data = 80'hDEAD_BEEF_0123_4567_89AB;
    prog_wr_en   = 1'b1;
    base_addr    = 6'd10;
    instr_count  = 7'd1;
    start_a      = 1'b1;
    @(posedge clk); #1;
    prog_wr_en   = 1'b0;
    start_a      = 1'b0;
    wait_writes_a(w0 + 4, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_writes: got %0d expected 4", writes_a - w0); end
    wait_done_a(d0 + 1, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_done: got no done expected done"); end
    repeat (10) @(posedge clk);
    #1;
    for (int i = rd_a; i < writes_a && i < 64; i++) begin
      checks++;
      if (exp_q_a.size() == 0) begin errors++; $display("FAIL wrap_order: got unexpected write %h expected none", obs_word_a[i]); end
      else begin
        e = exp_q_a.pop_front();
        if ({obs_we_a[i], obs_word_a[i]} !== {3'b111, e})
          begin errors++; $display("FAIL wrap_order: got we=%b %h expected we=111 %h", obs_we_a[i], obs_word_a[i], e); end
      end
    end
    rd_a = writes_a;
    exp_issued_a += 4;
    checks++;
    if (obs_word_a[w0 + 2] !== model_mem[0])
      begin errors++; $display("FAIL busy_write_dropped: got %h expected %h", obs_word_a[w0 + 2], model_mem[0]); end
    checks++;
    if (dones_a != d0 + 1 || icnt_a !== 32'(exp_issued_a) || busy_a !== 1'b0)
      begin errors++; $display("FAIL wrap_status: got dones=%0d icnt=%0d busy=%b expected 1 %0d 0",
        dones_a - d0, icnt_a, busy_a, exp_issued_a); end
  endtask

  task automatic test_abort();
    bit ok; int w0, d0;
    logic [79:0] e;
    for (int i = 0; i < 4; i++) exp_q_a.push_back(model_mem[i]);
    w0 = writes_a; d0 = dones_a;
    start_run_a(0, 4);
    wait_writes_a(w0 + 4, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_writes: got %0d expected 4", writes_a - w0); end
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (busy_a !== 1'b0 || we_a !== 3'b000)
      begin errors++; $display("FAIL abort_idle: got busy=%b we=%b expected busy=0 we=000", busy_a, we_a); end
    pulse_sync();
    repeat (20) @(posedge clk);
    #1;
    for (int i = rd_a; i < writes_a && i < 64; i++) begin
      checks++;
      if (exp_q_a.size() == 0) begin errors++; $display("FAIL abort_order: got unexpected write %h expected none", obs_word_a[i]); end
      else begin
        e = exp_q_a.pop_front();
        if ({obs_we_a[i], obs_word_a[i]} !== {3'b111, e})
          begin errors++; $display("FAIL abort_order: got we=%b %h expected we=111 %h", obs_we_a[i], obs_word_a[i], e); end
      end
    end
    rd_a = writes_a;
    exp_issued_a += 4;
    checks++;
    if (dones_a != d0 || busy_a !== 1'b0 || icnt_a !== 32'(exp_issued_a))
      begin errors++; $display("FAIL abort_status: got dones=%0d busy=%b icnt=%0d expected 0 0 %0d",
        dones_a - d0, busy_a, icnt_a, exp_issued_a); end
  endtask

  task automatic test_reset_mid_run();
    bit ok; int w0, d0;
    logic [79:0] e;
    for (int i = 0; i < 4; i++) exp_q_a.push_back(model_mem[i]);
    w0 = writes_a; d0 = dones_a;
    start_run_a(0, 4);
    wait_writes_a(w0 + 1, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_first_write: got none expected one write"); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q_a.delete();
    exp_q_a.push_back(model_mem[0]);
    @(negedge clk); #1;
    checks++;
    if (busy_a !== 1'b0 || icnt_a !== 32'd0 || we_a !== 3'b000 || done_a !== 1'b0 ||
        {upper_a, middle_a, lower_a} !== 80'd0)
      begin errors++; $display("FAIL rst_state: got busy=%b icnt=%0d we=%b done=%b words=%h expected all zero",
        busy_a, icnt_a, we_a, done_a, {upper_a, middle_a, lower_a}); end
    repeat (20) @(posedge clk);
    #1;
    for (int i = rd_a; i < writes_a && i < 64; i++) begin
      checks++;
      if (exp_q_a.size() == 0) begin errors++; $display("FAIL rst_order: got unexpected write %h expected none", obs_word_a[i]); end
      else begin
        e = exp_q_a.pop_front();
        if ({obs_we_a[i], obs_word_a[i]} !== {3'b111, e})
          begin errors++; $display("FAIL rst_order: got we=%b %h expected we=111 %h", obs_we_a[i], obs_word_a[i], e); end
      end
    end
    rd_a = writes_a;
    checks++;
    if (dones_a != d0 || writes_a != w0 + 1 || busy_a !== 1'b0)
      begin errors++; $display("FAIL rst_status: got dones=%0d writes=%0d busy=%b expected 0 1 0",
        dones_a - d0, writes_a - w0, busy_a); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fifo_stall();
    test_zero_count();
    test_sync_timeout();
    test_wrap_and_busy();
    test_abort();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
